spi_wbuf_6502: RTL and testbench

// - Write-coalescing buffer between cache_6502 (upstream) and spi_sram_master (downstream) on the mem_* bus.
// - Absorbs single-byte CPU writes to consecutive addresses and acks them without waiting for SPI.
// - Drains each run as one SPI write burst.
// - Reads pass through; any buffered run is flushed before a read, so SRAM is always coherent with the CPU.

---
 rtl/spi_wbuf_pkg.sv | 15 +
 rtl/wbuf_store.sv | 31 +++
 rtl/spi_wbuf_6502.sv | 162 ++++++++++++++++
 tb/tb_spi_wbuf_6502.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_wbuf_pkg.sv
// Shared types and widths for the SPI write-coalescing buffer.
//   wbuf_state_t : controller states
//   ADDR_W       : byte address width of the mem_* bus
//   DATA_W       : data byte width
package spi_wbuf_pkg;
  localparam int ADDR_W = 24;
  localparam int DATA_W = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACK   = 2'd1,
    FLUSH = 2'd2,
    READ  = 2'd3
  } wbuf_state_t;
endpackage

// File: rtl/wbuf_store.sv
// Byte register file holding the run of coalesced write data.
//   clk   : rising-edge clock
//   we    : write enable for widx/wdata
//   widx  : write slot
//   wdata : byte to store
//   ridx  : read slot
//   rdata : byte at ridx (combinational)
// Data flops carry no reset; occupancy is tracked by the controller.
module wbuf_store
  import spi_wbuf_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int IDX_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [IDX_W-1:0]  widx,
  input  logic [DATA_W-1:0] wdata,
  input  logic [IDX_W-1:0]  ridx,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem_q[widx] <= wdata;
  end

  assign rdata = mem_q[ridx];

endmodule

// File: rtl/spi_wbuf_6502.sv
// Write-coalescing buffer between the CPU-side cache and the SPI SRAM master.
// Single-byte writes to consecutive addresses are acked immediately and
// collected; a run is drained as one SPI write burst when it cannot grow,
// when a read arrives, or after FLUSH_TIMEOUT idle cycles.
//   clk, rst                        : clock, asynchronous active-high reset
//   up_addr/up_en/up_wr/up_wdata    : upstream request (held until up_rdy)
//   up_rdy/up_rdata                 : upstream completion pulse / read byte
//   mem_addr/mem_en/mem_wr          : downstream request, registered
//   mem_wburst/mem_wdata            : burst continuation flag / current byte
//   mem_rdy/mem_rdata               : downstream per-byte completion / read byte
module spi_wbuf_6502
  import spi_wbuf_pkg::*;
#(
  parameter int DEPTH         = 4,
  parameter int FLUSH_TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] up_addr,
  input  logic              up_en,
  input  logic              up_wr,
  input  logic [DATA_W-1:0] up_wdata,
  output logic              up_rdy,
  output logic [DATA_W-1:0] up_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_en,
  output logic              mem_wr,
  output logic              mem_wburst,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_rdy,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int TMR_W = $clog2(FLUSH_TIMEOUT + 1);

  wbuf_state_t       state_q, state_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [TMR_W-1:0]  timer_q, timer_d;
  logic              mem_en_q, mem_en_d;
  logic              mem_wr_q, mem_wr_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;

  logic              store_we;
  logic [DATA_W-1:0] store_rdata;
  logic [ADDR_W:0]   next_addr;
  logic              append_ok;
  logic              last_beat;

  wbuf_store #(.DEPTH(DEPTH)) store_inst (
    .clk   (clk),
    .we    (store_we),
    .widx  (count_q[IDX_W-1:0]),
    .wdata (up_wdata),
    .ridx  (idx_q),
    .rdata (store_rdata)
  );

  // The extra top bit catches a run that would wrap 0xFFFFFF -> 0x000000,
  // which SPI cannot express as one burst.
  assign next_addr = {1'b0, base_q} + (ADDR_W + 1)'(count_q);
  assign append_ok = (count_q == '0) ||
                     ((count_q < CNT_W'(DEPTH)) && !next_addr[ADDR_W] &&
                      (next_addr[ADDR_W-1:0] == up_addr));
  assign last_beat = (CNT_W'(idx_q) == (count_q - CNT_W'(1)));

  always_comb begin
    state_d    = state_q;
    base_d     = base_q;
    count_d    = count_q;
    idx_d      = idx_q;
    timer_d    = '0;
    mem_en_d   = mem_en_q;
    mem_wr_d   = mem_wr_q;
    mem_addr_d = mem_addr_q;
    store_we   = 1'b0;

    case (state_q)
      IDLE: begin
        if (up_en && up_wr && append_ok) begin
          store_we = 1'b1;
          count_d  = count_q + CNT_W'(1);
          if (count_q == '0) base_d = up_addr;
          state_d  = ACK;
        end else if (up_en && !up_wr && (count_q == '0)) begin
          state_d    = READ;
          mem_en_d   = 1'b1;
          mem_wr_d   = 1'b0;
          mem_addr_d = up_addr;
        end else if (up_en ||
                     ((count_q != '0) && (timer_q == TMR_W'(FLUSH_TIMEOUT - 1)))) begin
          // Blocked write, read behind buffered data, or idle timeout.
          // A pending request is re-evaluated here once the run is drained.
          state_d    = FLUSH;
          mem_en_d   = 1'b1;
          mem_wr_d   = 1'b1;
          mem_addr_d = base_q;
          idx_d      = '0;
        end else if (count_q != '0) begin
          timer_d = timer_q + TMR_W'(1);
        end
      end
      ACK: state_d = IDLE;
      FLUSH: begin
        if (mem_rdy) begin
          if (last_beat) begin
            count_d    = '0;
            idx_d      = '0;
            mem_en_d   = 1'b0;
            mem_wr_d   = 1'b0;
            mem_addr_d = '0;
            state_d    = IDLE;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      READ: begin
        if (mem_rdy) begin
          mem_en_d   = 1'b0;
          mem_addr_d = '0;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      base_q     <= '0;
      count_q    <= '0;
      idx_q      <= '0;
      timer_q    <= '0;
      mem_en_q   <= 1'b0;
      mem_wr_q   <= 1'b0;
      mem_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      base_q     <= base_d;
      count_q    <= count_d;
      idx_q      <= idx_d;
      timer_q    <= timer_d;
      mem_en_q   <= mem_en_d;
      mem_wr_q   <= mem_wr_d;
      mem_addr_q <= mem_addr_d;
    end
  end

  assign mem_en     = mem_en_q;
  assign mem_wr     = mem_wr_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wburst = (state_q == FLUSH) && (CNT_W'(idx_q) < (count_q - CNT_W'(1)));
  assign mem_wdata  = (state_q == FLUSH) ? store_rdata : '0;
  assign up_rdy     = (state_q == ACK) || ((state_q == READ) && mem_rdy);
  assign up_rdata   = (state_q == READ) ? mem_rdata : '0;

endmodule

// File: tb/tb_spi_wbuf_6502.sv
// Scoreboard bench for spi_wbuf_6502: directed requests push expected burst
// beats and read results into queues; a monitor pops and compares them as
// the downstream model completes bytes and the DUT acks reads.
module tb_spi_wbuf_6502;
  localparam int DEPTH = 4;
  localparam int FT    = 16;
  localparam int LAT   = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [23:0] up_addr = '0;
  logic        up_en = 1'b0;
  logic        up_wr = 1'b0;
  logic [7:0]  up_wdata = '0;
  logic        up_rdy;
  logic [7:0]  up_rdata;
  logic [23:0] mem_addr;
  logic        mem_en, mem_wr, mem_wburst;
  logic [7:0]  mem_wdata;
  logic        mem_rdy = 1'b0;
  logic [7:0]  mem_rdata = '0;

  always #5 clk = ~clk;

  spi_wbuf_6502 #(.DEPTH(DEPTH), .FLUSH_TIMEOUT(FT)) dut (
    .clk(clk), .rst(rst), .up_addr(up_addr), .up_en(up_en), .up_wr(up_wr),
    .up_wdata(up_wdata), .up_rdy(up_rdy), .up_rdata(up_rdata),
    .mem_addr(mem_addr), .mem_en(mem_en), .mem_wr(mem_wr),
    .mem_wburst(mem_wburst), .mem_wdata(mem_wdata), .mem_rdy(mem_rdy),
    .mem_rdata(mem_rdata)
  );

  typedef struct packed {
    logic [23:0] addr;
    logic [7:0]  data;
    logic        burst;
  } beat_t;

  beat_t wq[$];
  beat_t rq[$];
  int n_cmp = 0;
  int n_bad = 0;
  int wbeats = 0;
  logic [7:0] sram [logic [23:0]];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic beat_t mk(input logic [23:0] a, input logic [7:0] d, input logic b);
    beat_t e;
    e.addr = a; e.data = d; e.burst = b;
    return e;
  endfunction

  // Downstream SRAM model: LAT wait cycles, then a one-cycle mem_rdy per byte.
  initial begin : ds_model
    int wait_cnt;
    int beat;
    logic [23:0] a;
    wait_cnt = 0;
    beat = 0;
    forever begin
      @(negedge clk);
      if (rst || !mem_en) begin
        mem_rdy = 1'b0; wait_cnt = 0; beat = 0;
      end else if (mem_rdy) begin
        mem_rdy = 1'b0;
      end else if (wait_cnt < LAT) begin
        wait_cnt++;
      end else begin
        wait_cnt = 0;
        mem_rdy = 1'b1;
        a = mem_addr + 24'(beat);
        if (mem_wr) begin
          sram[a] = mem_wdata;
          beat++;
        end else begin
          mem_rdata = sram.exists(a) ? sram[a] : 8'h00;
        end
      end
    end
  end

  initial begin : monitor
    beat_t e;
    forever begin
      @(negedge clk); #1;
      if (!rst) begin
        if (mem_en && mem_wr) chk("no_ack_in_flush", up_rdy, 0);
        if (mem_rdy && mem_en && mem_wr) begin
          wbeats++;
          chk("wbeat_expected", wq.size() != 0, 1);
          if (wq.size() != 0) begin
            e = wq.pop_front();
            chk("burst_addr", mem_addr, e.addr);
            chk("burst_data", mem_wdata, e.data);
            chk("burst_wburst", mem_wburst, e.burst);
          end
        end
        if (up_rdy && !up_wr) begin
          chk("read_expected", rq.size() != 0, 1);
          if (rq.size() != 0) begin
            e = rq.pop_front();
            chk("read_addr", mem_addr, e.addr);
            chk("read_data", up_rdata, e.data);
            chk("flush_before_read", wq.size(), 0);
          end
        end
      end
    end
  end

  // Issue one request, wait for up_rdy, then leave one idle cycle.
  task automatic req(input logic wr, input logic [23:0] a, input logic [7:0] d,
                     input int exp_lat, output int lat);
    up_en = 1'b1; up_wr = wr; up_addr = a; up_wdata = d; lat = 0;
    do begin
      @(negedge clk); #1; lat++;
    end while (!up_rdy && lat < 400);
    chk("req_acked", up_rdy, 1);
    if (exp_lat >= 0) chk("ack_latency", lat, exp_lat);
    up_en = 1'b0;
    @(negedge clk); #1;
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while ((wq.size() != 0 || mem_en) && n < 300) begin
      @(negedge clk); #1; n++;
    end
    chk(name, (wq.size() == 0) && !mem_en, 1);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int lat, n, seen, start;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_up_rdy", up_rdy, 0);
    chk("rst_up_rdata", up_rdata, 0);
    chk("rst_mem_en", mem_en, 0);
    chk("rst_mem_wr", mem_wr, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wburst", mem_wburst, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    rst = 1'b0;
    @(negedge clk); #1;

    // Coalesce four consecutive bytes into one burst
    for (int i = 0; i < 4; i++) wq.push_back(mk(24'h000100, 8'h10 + 8'(i), i < 3));
    for (int i = 0; i < 4; i++) req(1'b1, 24'h000100 + 24'(i), 8'h10 + 8'(i), 1, lat);
    drain("coalesce_drain");

    // Non-contiguous write stalls behind a 1-byte flush
    wq.push_back(mk(24'h000200, 8'h40, 1'b0));
    req(1'b1, 24'h000200, 8'h40, 1, lat);
    req(1'b1, 24'h000300, 8'h41, -1, lat);
    chk("noncontig_stalled", lat > 1, 1);
    chk("noncontig_flush_before_ack", wq.size(), 0);
    wq.push_back(mk(24'h000300, 8'h41, 1'b0));
    drain("noncontig_drain");

    // Read after write returns the flushed byte
    wq.push_back(mk(24'h000050, 8'hAB, 1'b0));
    req(1'b1, 24'h000050, 8'hAB, 1, lat);
    rq.push_back(mk(24'h000050, 8'hAB, 1'b0));
    req(1'b0, 24'h000050, 8'h00, -1, lat);
    chk("raw_read_done", rq.size(), 0);
    drain("raw_drain");

    // Idle timeout, with restart on a second write
    wq.push_back(mk(24'h000400, 8'h01, 1'b1));
    wq.push_back(mk(24'h000400, 8'h02, 1'b0));
    req(1'b1, 24'h000400, 8'h01, 1, lat);
    seen = 0;
    repeat (10) begin
      @(negedge clk); #1;
      if (mem_en) seen++;
    end
    chk("no_early_flush", seen, 0);
    req(1'b1, 24'h000401, 8'h02, 1, lat);
    n = 0;
    do begin
      @(negedge clk); #1; n++;
    end while (!mem_en && n < 100);
    chk("timeout_cycles", n, FT);
    drain("timeout_drain");

    // Full buffer: 5 writes give bursts of 4 then 1
    for (int i = 0; i < 4; i++) wq.push_back(mk(24'h0000FC, 8'h20 + 8'(i), i < 3));
    wq.push_back(mk(24'h000100, 8'h24, 1'b0));
    for (int i = 0; i < 5; i++) req(1'b1, 24'h0000FC + 24'(i), 8'h20 + 8'(i), (i < 4) ? 1 : -1, lat);
    drain("full_drain");

    // Address wrap is never coalesced
    wq.push_back(mk(24'hFFFFFF, 8'h5A, 1'b0));
    wq.push_back(mk(24'h000000, 8'hA5, 1'b0));
    req(1'b1, 24'hFFFFFF, 8'h5A, 1, lat);
    req(1'b1, 24'h000000, 8'hA5, -1, lat);
    drain("wrap_drain");

    // Reset after the second byte of a 4-byte flush
    wq.push_back(mk(24'h000600, 8'h30, 1'b1));
    wq.push_back(mk(24'h000600, 8'h31, 1'b1));
    for (int i = 0; i < 4; i++) req(1'b1, 24'h000600 + 24'(i), 8'h30 + 8'(i), 1, lat);
    start = wbeats;
    n = 0;
    while (wbeats < start + 2 && n < 300) begin
      @(negedge clk); #1; n++;
    end
    chk("reset_beat2_reached", wbeats - start, 2);
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    chk("abort_mem_en", mem_en, 0);
    chk("abort_mem_wr", mem_wr, 0);
    chk("abort_mem_addr", mem_addr, 0);
    chk("abort_wburst", mem_wburst, 0);
    chk("abort_up_rdy", up_rdy, 0);
    @(negedge clk); #1;
    rst = 1'b0;
    seen = 0;
    repeat (40) begin
      @(negedge clk); #1;
      if (mem_en || up_rdy) seen++;
    end
    chk("abort_quiet", seen, 0);

    // Buffer starts empty after reset: a single write makes a 1-byte burst
    wq.push_back(mk(24'h000700, 8'h77, 1'b0));
    req(1'b1, 24'h000700, 8'h77, 1, lat);
    drain("post_reset_drain");

    chk("wq_empty_end", wq.size(), 0);
    chk("rq_empty_end", rq.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
